// File: rtl/conv2d_pkg.sv
// Shared types and helpers for the conv2d engine.
// Optional feature: define CONV2D_RELU_EN to fuse ReLU into requantisation.
package conv2d_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, WRITE, FIN} state_t;

  function automatic int acc_width(input int width_bit, input int ker, input int ch);
    return 2 * width_bit + $clog2(ker * ker * ch);
  endfunction

  function automatic int out_dim(input int img, input int ker, input int stride);
    return (img - ker) / stride + 1;
  endfunction

  // Clamp a shifted accumulator to the output range (non-negative with ReLU).
  function automatic longint saturate(input longint q, input int width_bit);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (width_bit - 1)) - 1;
`ifdef CONV2D_RELU_EN
    lo = 0;
`else
    lo = -hi - 1;
`endif
    if (q > hi) return hi;
    if (q < lo) return lo;
    return q;
  endfunction

endpackage

// File: rtl/conv2d_window_ctr.sv
// Channel / column / row counters for the window position, with terminal flags.
module conv2d_window_ctr #(
  parameter int CH   = 1,
  parameter int OUT  = 5,
  parameter int CH_W = 1,
  parameter int RC_W = 4
) (
  input  logic            clock,
  input  logic            nreset,
  input  logic            clear,
  input  logic            inc_ch,
  input  logic            inc_pix,
  output logic [CH_W-1:0] ch,
  output logic [RC_W-1:0] row,
  output logic [RC_W-1:0] col,
  output logic            last_ch,
  output logic            last_pix
);

  logic last_col;

  assign last_ch  = (ch == CH_W'(CH - 1));
  assign last_col = (col == RC_W'(OUT - 1));
  assign last_pix = last_col && (row == RC_W'(OUT - 1));

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      ch  <= '0;
      row <= '0;
      col <= '0;
    end else if (clear) begin
      ch  <= '0;
      row <= '0;
      col <= '0;
    end else if (inc_pix) begin
      ch <= '0;
      if (last_col) begin
        col <= '0;
        row <= last_pix ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end else if (inc_ch) begin
      ch <= ch + 1'b1;
    end
  end

endmodule

// File: rtl/conv2d_engine.sv
// Multi-channel 2-D convolution engine: LOAD/MAC per channel, WRITE per pixel.
// Optional feature: define CONV2D_RELU_EN to fuse ReLU into requantisation.
module conv2d_engine
  import conv2d_pkg::*;
#(
  parameter int IMG       = 7,
  parameter int KER       = 3,
  parameter int STRIDE    = 1,
  parameter int CH        = 1,
  parameter int WIDTH_BIT = 8,
  parameter int SHIFT     = 2,
  localparam int OUT      = out_dim(IMG, KER, STRIDE),
  localparam int RC_W     = $clog2(OUT) + 1
) (
  input  logic                        clock,
  input  logic                        nreset,
  input  logic                        start,
  input  logic signed [WIDTH_BIT-1:0] inp_matrix [CH][IMG][IMG],
  input  logic signed [WIDTH_BIT-1:0] kernel     [CH][KER][KER],
  output logic                        busy,
  output logic                        done,
  output logic                        pix_valid,
  output logic [RC_W-1:0]             pix_row,
  output logic [RC_W-1:0]             pix_col,
  output logic signed [WIDTH_BIT-1:0] pix_data,
  output logic signed [WIDTH_BIT-1:0] out_matrix [OUT][OUT]
);

  localparam int ACC_W = acc_width(WIDTH_BIT, KER, CH);
  localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;

  state_t                      state;
  logic signed [ACC_W-1:0]     acc;
  logic signed [ACC_W-1:0]     mac_sum;
  logic signed [WIDTH_BIT-1:0] win  [KER][KER];
  logic signed [WIDTH_BIT-1:0] kwin [KER][KER];
  logic signed [WIDTH_BIT-1:0] q;
  logic [CH_W-1:0]             ch;
  logic [RC_W-1:0]             row;
  logic [RC_W-1:0]             col;
  logic                        last_ch;
  logic                        last_pix;

  conv2d_window_ctr #(
    .CH  (CH),
    .OUT (OUT),
    .CH_W(CH_W),
    .RC_W(RC_W)
  ) u_ctr (
    .clock   (clock),
    .nreset  (nreset),
    .clear   (state == IDLE && start),
    .inc_ch  (state == MAC && !last_ch),
    .inc_pix (state == WRITE),
    .ch      (ch),
    .row     (row),
    .col     (col),
    .last_ch (last_ch),
    .last_pix(last_pix)
  );

  // NOTE: combinational accumulation uses blocking '=' so each term sees the running sum.
  always_comb begin
    mac_sum = '0;
    for (int k = 0; k < KER; k++)
      for (int l = 0; l < KER; l++)
        mac_sum = mac_sum + ACC_W'(win[k][l]) * ACC_W'(kwin[k][l]);
  end

  always_comb q = WIDTH_BIT'(saturate(longint'(acc >>> SHIFT), WIDTH_BIT));

  // NOTE: the window is scratch storage fully rewritten before use, so it carries no reset;
  // out_matrix is a visible output and is reset with the rest of the state.
  always_ff @(posedge clock) begin
    if (state == LOAD) begin
      for (int k = 0; k < KER; k++)
        for (int l = 0; l < KER; l++) begin
          win[k][l]  <= inp_matrix[ch][int'(row) * STRIDE + k][int'(col) * STRIDE + l];
          kwin[k][l] <= kernel[ch][k][l];
        end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      acc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pix_valid <= 1'b0;
      pix_row   <= '0;
      pix_col   <= '0;
      pix_data  <= '0;
      for (int r = 0; r < OUT; r++)
        for (int c = 0; c < OUT; c++)
          out_matrix[r][c] <= '0;
    end else begin
      done      <= 1'b0;
      pix_valid <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          acc   <= '0;
          busy  <= 1'b1;
          state <= LOAD;
        end
        LOAD: state <= MAC;
        MAC: begin
          acc   <= acc + mac_sum;
          state <= last_ch ? WRITE : LOAD;
        end
        WRITE: begin
          pix_valid             <= 1'b1;
          pix_row               <= row;
          pix_col               <= col;
          pix_data              <= q;
          out_matrix[row][col]  <= q;
          acc                   <= '0;
          state                 <= last_pix ? FIN : LOAD;
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_engine.sv
// Directed bench for conv2d_engine: three parameterisations sharing clock and reset.
module tb_conv2d_engine;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic nreset;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: defaults with SHIFT=0
  logic              start_a;
  logic signed [7:0] img_a [1][7][7];
  logic signed [7:0] ker_a [1][3][3];
  logic              busy_a, done_a, pv_a;
  logic [3:0]        row_a, col_a;
  logic signed [7:0] data_a;
  logic signed [7:0] out_a [5][5];

  // Instance B: defaults (SHIFT=2)
  logic              start_b;
  logic signed [7:0] img_b [1][7][7];
  logic signed [7:0] ker_b [1][3][3];
  logic              busy_b, done_b, pv_b;
  logic [3:0]        row_b, col_b;
  logic signed [7:0] data_b;
  logic signed [7:0] out_b [5][5];

  // Instance C: IMG=6 KER=2 STRIDE=2 CH=3 SHIFT=0
  logic              start_c;
  logic signed [7:0] img_c [3][6][6];
  logic signed [7:0] ker_c [3][2][2];
  logic              busy_c, done_c, pv_c;
  logic [2:0]        row_c, col_c;
  logic signed [7:0] data_c;
  logic signed [7:0] out_c [3][3];

  conv2d_engine #(.SHIFT(0)) dut_a (
    .clock(clock), .nreset(nreset), .start(start_a), .inp_matrix(img_a), .kernel(ker_a),
    .busy(busy_a), .done(done_a), .pix_valid(pv_a), .pix_row(row_a), .pix_col(col_a),
    .pix_data(data_a), .out_matrix(out_a));

  conv2d_engine dut_b (
    .clock(clock), .nreset(nreset), .start(start_b), .inp_matrix(img_b), .kernel(ker_b),
    .busy(busy_b), .done(done_b), .pix_valid(pv_b), .pix_row(row_b), .pix_col(col_b),
    .pix_data(data_b), .out_matrix(out_b));

  conv2d_engine #(.IMG(6), .KER(2), .STRIDE(2), .CH(3), .SHIFT(0)) dut_c (
    .clock(clock), .nreset(nreset), .start(start_c), .inp_matrix(img_c), .kernel(ker_c),
    .busy(busy_c), .done(done_c), .pix_valid(pv_c), .pix_row(row_c), .pix_col(col_c),
    .pix_data(data_c), .out_matrix(out_c));

  int pr [25];
  int pc [25];
  int pd [25];
  int npix;
  int first_pix;

  task automatic set_a(input int iv, input int kv);
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) img_a[0][r][c] = 8'(iv);
    for (int k = 0; k < 3; k++)
      for (int l = 0; l < 3; l++) ker_a[0][k][l] = 8'(kv);
  endtask

  // Start a frame on A; cyc counts edges after the start-sampling edge until done is seen.
  task automatic run_a(input int repulse_at, output int cyc);
    npix = 0;
    first_pix = -1;
    @(negedge clock) start_a = 1'b1;
    @(negedge clock) start_a = 1'b0;
    cyc = 0;
    while (cyc < 300 && !done_a) begin
      @(negedge clock);
      cyc++;
      start_a = (cyc == repulse_at);
      if (pv_a) begin
        if (first_pix < 0) first_pix = cyc;
        if (npix < 25) begin
          pr[npix] = int'(row_a);
          pc[npix] = int'(col_a);
          pd[npix] = int'(data_a);
        end
        npix++;
      end
    end
    start_a = 1'b0;
  endtask

  task automatic test_reset;
    int nz;
    nreset = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    set_a(0, 0);
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) begin img_b[0][r][c] = '0; end
    for (int k = 0; k < 3; k++)
      for (int l = 0; l < 3; l++) ker_b[0][k][l] = '0;
    for (int ch = 0; ch < 3; ch++)
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++) img_c[ch][r][c] = '0;
    for (int ch = 0; ch < 3; ch++)
      for (int k = 0; k < 2; k++)
        for (int l = 0; l < 2; l++) ker_c[ch][k][l] = '0;
    repeat (2) @(negedge clock);
    n_checks++;
    if ({busy_a, done_a, pv_a, row_a, col_a, data_a} !== '0) begin
      n_fail++; $display("FAIL reset_outputs_a: got %h expected 0", {busy_a, done_a, pv_a, row_a, col_a, data_a});
    end
    n_checks++;
    if ({busy_b, done_b, pv_b, busy_c, done_c, pv_c} !== '0) begin
      n_fail++; $display("FAIL reset_outputs_bc: got %b expected 0", {busy_b, done_b, pv_b, busy_c, done_c, pv_c});
    end
    nz = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) if (out_a[r][c] !== 8'sd0 || out_b[r][c] !== 8'sd0) nz++;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) if (out_c[r][c] !== 8'sd0) nz++;
    n_checks++;
    if (nz != 0) begin
      n_fail++; $display("FAIL reset_matrix: got %0d nonzero entries expected 0", nz);
    end
    @(negedge clock) nreset = 1'b1;
  endtask

  task automatic test_ones;
    int cyc;
    set_a(1, 1);
    run_a(0, cyc);
    n_checks++;
    if (cyc != 76) begin n_fail++; $display("FAIL ones_frame_cycles: got %0d expected 76", cyc); end
    n_checks++;
    if (first_pix != 3) begin n_fail++; $display("FAIL ones_first_pix: got %0d expected 3", first_pix); end
    n_checks++;
    if (npix != 25) begin n_fail++; $display("FAIL ones_pix_count: got %0d expected 25", npix); end
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        n_checks++;
        if (out_a[r][c] !== 8'sd9) begin
          n_fail++; $display("FAIL ones_out[%0d][%0d]: got %0d expected 9", r, c, out_a[r][c]);
        end
      end
    @(negedge clock);
    n_checks++;
    if ({done_a, busy_a} !== 2'b00) begin
      n_fail++; $display("FAIL ones_done_pulse: got done,busy=%b expected 00", {done_a, busy_a});
    end
  endtask

  task automatic test_ramp;
    int cyc;
    int exp;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) img_a[0][r][c] = 8'(r * c);
    for (int k = 0; k < 3; k++)
      for (int l = 0; l < 3; l++) ker_a[0][k][l] = 8'(3 * k + l - 4);
    run_a(0, cyc);
    n_checks++;
    if (cyc != 76) begin n_fail++; $display("FAIL ramp_frame_cycles: got %0d expected 76", cyc); end
    for (int i = 0; i < 25; i++) begin
      exp = 6 * (i / 5) + 18 * (i % 5) + 24;
      n_checks++;
      if (pr[i] != i / 5 || pc[i] != i % 5 || pd[i] != exp) begin
        n_fail++;
        $display("FAIL ramp_stream[%0d]: got (%0d,%0d)=%0d expected (%0d,%0d)=%0d", i, pr[i], pc[i], pd[i], i / 5, i % 5, exp);
      end
      n_checks++;
      if (int'(out_a[i / 5][i % 5]) != exp) begin
        n_fail++; $display("FAIL ramp_out[%0d][%0d]: got %0d expected %0d", i / 5, i % 5, out_a[i / 5][i % 5], exp);
      end
    end
  endtask

  task automatic test_negative;
    int cyc;
    int exp;
`ifdef CONV2D_RELU_EN
    exp = 0;
`else
    exp = -36;
`endif
    set_a(4, -1);
    run_a(0, cyc);
    n_checks++;
    if (cyc != 76) begin n_fail++; $display("FAIL neg_frame_cycles: got %0d expected 76", cyc); end
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        n_checks++;
        if (int'(out_a[r][c]) != exp) begin
          n_fail++; $display("FAIL neg_out[%0d][%0d]: got %0d expected %0d", r, c, out_a[r][c], exp);
        end
      end
  endtask

  task automatic test_saturation;
    int cyc;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) img_b[0][r][c] = 8'sd10;
    for (int k = 0; k < 3; k++)
      for (int l = 0; l < 3; l++) ker_b[0][k][l] = 8'sd10;
    @(negedge clock) start_b = 1'b1;
    @(negedge clock) start_b = 1'b0;
    cyc = 0;
    while (cyc < 300 && !done_b) begin
      @(negedge clock);
      cyc++;
    end
    n_checks++;
    if (cyc != 76) begin n_fail++; $display("FAIL sat_frame_cycles: got %0d expected 76", cyc); end
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        n_checks++;
        if (out_b[r][c] !== 8'sd127) begin
          n_fail++; $display("FAIL sat_out[%0d][%0d]: got %0d expected 127", r, c, out_b[r][c]);
        end
      end
  endtask

  task automatic test_stride;
    int cyc;
    int n;
    int first;
    for (int ch = 0; ch < 3; ch++)
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++) img_c[ch][r][c] = 8'(ch + 1);
    for (int ch = 0; ch < 3; ch++)
      for (int k = 0; k < 2; k++)
        for (int l = 0; l < 2; l++) ker_c[ch][k][l] = 8'sd1;
    @(negedge clock) start_c = 1'b1;
    @(negedge clock) start_c = 1'b0;
    cyc = 0;
    n = 0;
    first = -1;
    while (cyc < 300 && !done_c) begin
      @(negedge clock);
      cyc++;
      if (pv_c) begin
        if (first < 0) first = cyc;
        n_checks++;
        if (int'(row_c) != n / 3 || int'(col_c) != n % 3 || data_c !== 8'sd24) begin
          n_fail++;
          $display("FAIL stride_stream[%0d]: got (%0d,%0d)=%0d expected (%0d,%0d)=24", n, row_c, col_c, data_c, n / 3, n % 3);
        end
        n++;
      end
    end
    n_checks++;
    if (cyc != 64) begin n_fail++; $display("FAIL stride_frame_cycles: got %0d expected 64", cyc); end
    n_checks++;
    if (first != 7) begin n_fail++; $display("FAIL stride_first_pix: got %0d expected 7", first); end
    n_checks++;
    if (n != 9) begin n_fail++; $display("FAIL stride_pix_count: got %0d expected 9", n); end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        n_checks++;
        if (out_c[r][c] !== 8'sd24) begin
          n_fail++; $display("FAIL stride_out[%0d][%0d]: got %0d expected 24", r, c, out_c[r][c]);
        end
      end
  endtask

  task automatic test_back_to_back;
    int cyc;
    set_a(2, 1);
    run_a(10, cyc);
    n_checks++;
    if (cyc != 76) begin n_fail++; $display("FAIL repulse_frame_cycles: got %0d expected 76", cyc); end
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        n_checks++;
        if (out_a[r][c] !== 8'sd18) begin
          n_fail++; $display("FAIL repulse_out[%0d][%0d]: got %0d expected 18", r, c, out_a[r][c]);
        end
      end
    set_a(1, 1);
    run_a(75, cyc);
    n_checks++;
    if (cyc != 76) begin n_fail++; $display("FAIL fin_start_frame_cycles: got %0d expected 76", cyc); end
    n_checks++;
    if (out_a[4][4] !== 8'sd9) begin n_fail++; $display("FAIL fin_start_out: got %0d expected 9", out_a[4][4]); end
    repeat (3) @(negedge clock);
    n_checks++;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL fin_start_ignored: got busy=%b expected 0", busy_a); end
  endtask

  task automatic test_reset_abort;
    int cyc;
    int nz;
    int seen;
    set_a(3, 1);
    @(negedge clock) start_a = 1'b1;
    @(negedge clock) start_a = 1'b0;
    repeat (20) @(negedge clock);
    n_checks++;
    if (busy_a !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b expected 1", busy_a); end
    nreset = 1'b0;
    #1;
    n_checks++;
    if ({busy_a, done_a, pv_a, row_a, col_a, data_a} !== '0) begin
      n_fail++; $display("FAIL abort_outputs: got %h expected 0", {busy_a, done_a, pv_a, row_a, col_a, data_a});
    end
    nz = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) if (out_a[r][c] !== 8'sd0) nz++;
    n_checks++;
    if (nz != 0) begin n_fail++; $display("FAIL abort_matrix: got %0d nonzero entries expected 0", nz); end
    @(negedge clock) nreset = 1'b1;
    seen = 0;
    repeat (100) begin
      @(negedge clock);
      if (done_a || busy_a) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d active cycles expected 0", seen); end
    run_a(0, cyc);
    n_checks++;
    if (cyc != 76) begin n_fail++; $display("FAIL abort_restart_cycles: got %0d expected 76", cyc); end
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        n_checks++;
        if (out_a[r][c] !== 8'sd27) begin
          n_fail++; $display("FAIL abort_restart_out[%0d][%0d]: got %0d expected 27", r, c, out_a[r][c]);
        end
      end
  endtask

  initial begin
    test_reset;
    test_ones;
    test_ramp;
    test_negative;
    test_saturation;
    test_stride;
    test_back_to_back;
    test_reset_abort;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
